// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole round controller.
package whack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PICK,
    SHOW,
    GAP,
    OVER
  } game_state_t;

  // Cycles at the start of SHOW during which the scanner's row/col pipeline
  // may still report a press belonging to the previous mole position.
  localparam int HIT_BLANK_CYC = 2;

  // Right-shifting Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1:
  // feedback is the XOR of register bits 0, 2, 3 and 5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // Width of a mole position {row, col}.
  localparam int POS_W = 4;

  // Never show the mole twice in a row at the same position.
  function automatic logic [POS_W-1:0] avoid_repeat(input logic [POS_W-1:0] raw,
                                                    input logic [POS_W-1:0] prev);
    return (raw == prev) ? raw + POS_W'(1) : raw;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit free-running Fibonacci LFSR; low POS_W bits give a mole position.
// The seed must be nonzero, which keeps the register out of the all-zero lock-up.
module mole_lfsr
  import whack_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [POS_W-1:0] pos
);

  logic [15:0] lfsr;

  // Shift right every cycle, feedback entering at the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end
  end

  assign pos = lfsr[POS_W-1:0];

endmodule

// File: rtl/mole_game_sequencer.sv
// Whack-a-mole round controller: picks mole positions, times show/gap windows,
// scores hits and misses, and runs the game-second countdown.
// Optional feature macro: WHACK_SPEEDUP_EN shortens the show window as the
// score grows (one SPEEDUP_STEP_MS per four hits, floored at SHOW_MIN_MS).
//
// Handshake: start_pulse is a one-cycle request honoured only in IDLE/OVER;
// mole_is_hitted is a level from the scanner, sampled only in SHOW after the
// blanking cycles, and at most one hit is taken per mole.
module mole_game_sequencer
  import whack_pkg::*;
#(
  parameter int          TICK_DIV        = 50000,
  parameter int          SHOW_MS         = 1000,
  parameter int          GAP_MS          = 300,
  parameter int          GAME_SEC        = 30,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int          SCORE_W         = 8,
  parameter int          SPEEDUP_STEP_MS = 50,
  parameter int          SHOW_MIN_MS     = 300
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_pulse,
  input  logic               mole_is_hitted,
  output logic               is_started,
  output logic [1:0]         mole_row,
  output logic [1:0]         mole_col,
  output logic               mole_visible,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] miss_count,
  output logic [7:0]         time_left,
  output logic               game_over
);

  localparam int                 MS_W      = 16;
  localparam int                 PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [9:0]         SEC_LAST  = 10'd999;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  game_state_t      state;
  logic [PRE_W-1:0] pre_cnt;    // game-clock prescaler (seconds countdown)
  logic [PRE_W-1:0] ms_pre;     // mole-window prescaler, restarted on each load
  logic [9:0]       sec_cnt;
  logic [MS_W-1:0]  ms_cnt;
  logic [MS_W-1:0]  show_ms;
  logic [1:0]       blank_cnt;
  logic [POS_W-1:0] lfsr_pos;
  logic [POS_W-1:0] prev_pos;
  logic [POS_W-1:0] pick_pos;
  logic             running;
  logic             game_tick;
  logic             ms_tick;
  logic             hit_ok;

  mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .pos   (lfsr_pos)
  );

  assign running   = (state == PICK) || (state == SHOW) || (state == GAP);
  assign game_tick = (pre_cnt == PRE_LAST);
  // The window prescaler restarts with every ms_cnt load so that each show
  // and gap window lasts exactly N*TICK_DIV cycles regardless of game phase.
  assign ms_tick   = (ms_pre == PRE_LAST);
  assign hit_ok    = mole_is_hitted && (blank_cnt == 2'(HIT_BLANK_CYC));
  assign pick_pos  = avoid_repeat(lfsr_pos, prev_pos);

`ifdef WHACK_SPEEDUP_EN
  logic [31:0] speedup_ms;

  // Shrink the show window by one step per four hits without underflowing.
  always_comb begin
    speedup_ms = 32'(score >> 2) * 32'(SPEEDUP_STEP_MS);
    if (speedup_ms + 32'(SHOW_MIN_MS) >= 32'(SHOW_MS)) begin
      show_ms = MS_W'(SHOW_MIN_MS);
    end else begin
      show_ms = MS_W'(32'(SHOW_MS) - speedup_ms);
    end
  end
`else
  logic unused_speedup_cfg;
  assign show_ms            = MS_W'(SHOW_MS);
  assign unused_speedup_cfg = ^{SPEEDUP_STEP_MS, SHOW_MIN_MS};
`endif

  // Round FSM with its timers, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      is_started   <= 1'b0;
      mole_row     <= '0;
      mole_col     <= '0;
      mole_visible <= 1'b0;
      score        <= '0;
      miss_count   <= '0;
      time_left    <= 8'(GAME_SEC);
      game_over    <= 1'b0;
      prev_pos     <= '0;
      pre_cnt      <= '0;
      ms_pre       <= '0;
      sec_cnt      <= '0;
      ms_cnt       <= '0;
      blank_cnt    <= '0;
    end else begin
      if (running) begin
        if (game_tick) begin
          pre_cnt <= '0;
          if (sec_cnt == SEC_LAST) begin
            sec_cnt <= '0;
            if (time_left != 8'd0) time_left <= time_left - 8'd1;
          end else begin
            sec_cnt <= sec_cnt + 10'd1;
          end
        end else begin
          pre_cnt <= pre_cnt + PRE_W'(1);
        end
      end

      if ((state == SHOW) || (state == GAP)) begin
        ms_pre <= ms_tick ? '0 : ms_pre + PRE_W'(1);
      end

      case (state)
        IDLE, OVER: begin
          if (start_pulse) begin
            score      <= '0;
            miss_count <= '0;
            pre_cnt    <= '0;
            sec_cnt    <= '0;
            time_left  <= 8'(GAME_SEC);
            is_started <= 1'b1;
            game_over  <= 1'b0;
            state      <= PICK;
          end
        end
        PICK: begin
          {mole_row, mole_col} <= pick_pos;
          prev_pos     <= pick_pos;
          ms_cnt       <= show_ms;
          ms_pre       <= '0;
          blank_cnt    <= '0;
          mole_visible <= 1'b1;
          state        <= SHOW;
        end
        SHOW: begin
          if (blank_cnt != 2'(HIT_BLANK_CYC)) blank_cnt <= blank_cnt + 2'd1;
          if (hit_ok || (ms_tick && (ms_cnt <= MS_W'(1)))) begin
            if (hit_ok) begin
              if (score != SCORE_MAX) score <= score + SCORE_W'(1);
            end else begin
              if (miss_count != SCORE_MAX) miss_count <= miss_count + SCORE_W'(1);
            end
            ms_cnt       <= MS_W'(GAP_MS);
            ms_pre       <= '0;
            mole_visible <= 1'b0;
            state        <= GAP;
          end else if (ms_tick) begin
            ms_cnt <= ms_cnt - MS_W'(1);
          end
        end
        GAP: begin
          if (ms_tick) begin
            if (ms_cnt <= MS_W'(1)) state <= PICK;
            else ms_cnt <= ms_cnt - MS_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Countdown expiry wins over the state move but not over this cycle's scoring.
      if (running && (time_left == 8'd0)) begin
        state        <= OVER;
        is_started   <= 1'b0;
        mole_visible <= 1'b0;
        game_over    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mole_game_sequencer.sv
// Directed bench for mole_game_sequencer with shortened timing:
// TICK_DIV=4, SHOW_MS=10, GAP_MS=3, GAME_SEC=2 (show=40, gap=12 cycles).
module tb_mole_game_sequencer;

  localparam int          TICK_DIV        = 4;
  localparam int          SHOW_MS         = 10;
  localparam int          GAP_MS          = 3;
  localparam int          GAME_SEC        = 2;
  localparam int          SCORE_W         = 8;
  localparam int          SPEEDUP_STEP_MS = 1;
  localparam int          SHOW_MIN_MS     = 3;
  localparam logic [15:0] SEED            = 16'hACE1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_pulse = 1'b0;
  logic mole_is_hitted = 1'b0;

  logic               is_started;
  logic [1:0]         mole_row;
  logic [1:0]         mole_col;
  logic               mole_visible;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] miss_count;
  logic [7:0]         time_left;
  logic               game_over;

  always #5 clk = ~clk;

  mole_game_sequencer #(
    .TICK_DIV        (TICK_DIV),
    .SHOW_MS         (SHOW_MS),
    .GAP_MS          (GAP_MS),
    .GAME_SEC        (GAME_SEC),
    .LFSR_SEED       (SEED),
    .SCORE_W         (SCORE_W),
    .SPEEDUP_STEP_MS (SPEEDUP_STEP_MS),
    .SHOW_MIN_MS     (SHOW_MIN_MS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_pulse    (start_pulse),
    .mole_is_hitted (mole_is_hitted),
    .is_started     (is_started),
    .mole_row       (mole_row),
    .mole_col       (mole_col),
    .mole_visible   (mole_visible),
    .score          (score),
    .miss_count     (miss_count),
    .time_left      (time_left),
    .game_over      (game_over)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Position model: LFSR x^16+x^14+x^13+x^11+1 shifting right, pos = low nibble
  // of the value held during PICK, bumped by one if it repeats the last mole.
  logic [15:0] m_lfsr;
  logic [15:0] lfsr_prev;
  logic [3:0]  m_prev;
  logic [3:0]  mon_p;
  logic        vis_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      m_prev    = 4'd0;
      vis_q     = 1'b0;
      lfsr_prev = m_lfsr;
    end else begin
      if (mole_visible && !vis_q) begin
        mon_p = lfsr_prev[3:0];
        if (mon_p == m_prev) mon_p = mon_p + 4'd1;
        exp_q.push_back(mon_p);
        m_prev = mon_p;
      end
      vis_q     = mole_visible;
      lfsr_prev = m_lfsr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_pulse = 1'b1;
    step();
    start_pulse = 1'b0;
  endtask

  // Cycles spent with mole_visible at the given level (bounded).
  task automatic measure(input logic level, output int cnt);
    cnt = 0;
    while ((mole_visible === level) && (cnt < 200)) begin
      cnt++;
      step();
    end
  endtask

  task automatic check_pos();
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      check("pos_pending", 32'(exp_q.size()), 1);
    end else begin
      e = exp_q.pop_front();
      check("mole_pos", 32'({mole_row, mole_col}), 32'(e));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_is_started"}, 32'(is_started), 0);
    check({tag, "_visible"},    32'(mole_visible), 0);
    check({tag, "_score"},      32'(score), 0);
    check({tag, "_miss"},       32'(miss_count), 0);
    check({tag, "_time_left"},  32'(time_left), GAME_SEC);
    check({tag, "_game_over"},  32'(game_over), 0);
    check({tag, "_row"},        32'(mole_row), 0);
    check({tag, "_col"},        32'(mole_col), 0);
  endtask

  // Runs until game_over; returns cycles after the start edge (bounded).
  task automatic run_to_over(input logic hits_mode, output int cnt, output int rises);
    logic prev_vis;
    cnt = 0;
    rises = 0;
    prev_vis = mole_visible;
    while (!game_over && (cnt < 9000)) begin
      step();
      cnt++;
      if (mole_visible && !prev_vis) rises++;
      prev_vis = mole_visible;
      if (!hits_mode && cnt == 3999) check("time_left_before_1s", 32'(time_left), 2);
      if (!hits_mode && cnt == 4000) check("time_left_after_1s", 32'(time_left), 1);
      // Held key scores at the third SHOW cycle of every 16-cycle mole: hit m lands at edge 4+16m.
      if (hits_mode && cnt == 4067) check("score_254", 32'(score), 254);
      if (hits_mode && cnt == 4068) check("score_255", 32'(score), 255);
    end
  endtask

  // Watchdog: a hung run still reports.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cnt;
    int rises;
    logic [3:0] old_pos;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    step();
    rst_n = 1'b1;
    step();
    step();
    check("idle_not_started", 32'(is_started), 0);

    // 1: start -> running next cycle, PICK then SHOW
    pulse_start();
    check("start_is_started", 32'(is_started), 1);
    check("start_time_left", 32'(time_left), GAME_SEC);
    check("pick_not_visible", 32'(mole_visible), 0);
    step();
    check("show_visible", 32'(mole_visible), 1);
    check_pos();

    // 2: no hit -> 40-cycle show, miss, 12-cycle gap + 1 PICK cycle
    measure(1'b1, cnt);
    check("show_len", 32'(cnt), 40);
    check("miss_after_timeout", 32'(miss_count), 1);
    check("score_after_timeout", 32'(score), 0);
    old_pos = {mole_row, mole_col};
    measure(1'b0, cnt);
    check("gap_pick_len", 32'(cnt), 13);
    check_pos();
    check("pos_changed", 32'({mole_row, mole_col} != old_pos), 1);

    // 3: hit in 2nd SHOW cycle blanked, 3rd cycle scores, held key scores once
    step();
    mole_is_hitted = 1'b1;
    step();
    check("hit_blanked", 32'(score), 0);
    check("hit_blanked_visible", 32'(mole_visible), 1);
    step();
    check("hit_scored", 32'(score), 1);
    check("hit_to_gap", 32'(mole_visible), 0);
    check("hit_no_miss", 32'(miss_count), 1);
    repeat (5) step();
    check("held_key_once", 32'(score), 1);
    mole_is_hitted = 1'b0;
    pulse_start();
    check("start_ignored_score", 32'(score), 1);
    check("start_ignored_miss", 32'(miss_count), 1);
    check("start_ignored_running", 32'(is_started), 1);
    measure(1'b0, cnt);
    check_pos();

    // 4: full game, no hits: ends 8001 edges after start; 53-cycle moles -> 151 misses
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    exp_q.delete();
    pulse_start();
    run_to_over(1'b0, cnt, rises);
    check("game_len", 32'(cnt), 8001);
    check("over_game_over", 32'(game_over), 1);
    check("over_is_started", 32'(is_started), 0);
    check("over_visible", 32'(mole_visible), 0);
    check("over_time_left", 32'(time_left), 0);
    check("over_miss", 32'(miss_count), 151);
    check("over_score", 32'(score), 0);
    check("moles_shown", 32'(score) + 32'(miss_count), 32'(rises));
    repeat (20) step();
    check("over_held", 32'(game_over), 1);
    check("over_held_miss", 32'(miss_count), 151);

    // 5: key held all game -> saturates at 255; restart from OVER clears
    mole_is_hitted = 1'b1;
    pulse_start();
    check("restart_score", 32'(score), 0);
    check("restart_miss", 32'(miss_count), 0);
    check("restart_game_over", 32'(game_over), 0);
    run_to_over(1'b1, cnt, rises);
    check("game_len_hits", 32'(cnt), 8001);
    check("sat_score", 32'(score), 255);
    check("sat_miss", 32'(miss_count), 0);
    mole_is_hitted = 1'b0;
    pulse_start();
    check("restart2_score", 32'(score), 0);
    check("restart2_time_left", 32'(time_left), GAME_SEC);
    check("restart2_is_started", 32'(is_started), 1);
    check("restart2_game_over", 32'(game_over), 0);

    // 6: async reset mid-SHOW
    cnt = 0;
    while (!mole_visible && cnt < 50) begin
      step();
      cnt++;
    end
    check("mid_show_visible", 32'(mole_visible), 1);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    step();
    rst_n = 1'b1;
    step();

`ifdef WHACK_SPEEDUP_EN
    // score=8 -> show = max(3, 10 - (8>>2)*1) = 8 ms = 32 cycles
    exp_q.delete();
    pulse_start();
    mole_is_hitted = 1'b1;
    cnt = 0;
    while (score != 8'd8 && cnt < 500) begin
      step();
      cnt++;
    end
    mole_is_hitted = 1'b0;
    check("speedup_score", 32'(score), 8);
    measure(1'b0, cnt);
    measure(1'b1, cnt);
    check("speedup_show_len", 32'(cnt), 32);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
